// File: rtl/data_sync.sv
// data_sync: toggle-request / toggle-acknowledge data synchronizer.
// BUS_REQ crosses into the CLK domain through a NUM_STAGES flop chain. Each
// transition of the synchronized request captures one UNSYNC_BUS word. The
// word is then held on SYNC_BUS until the consumer accepts it, and the accept
// is returned to the source as a transition on ACK_TGL.
// Optional feature: define DATA_SYNC_OVERRUN_EN to enable the sticky OVERRUN
// flag. OVERRUN is set when a request arrives while a word is still held.
module data_sync #(
   parameter int NUM_STAGES = 2,
   parameter int BUS_WIDTH  = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
   input  logic                 BUS_REQ,
   output logic                 ACK_TGL,
   output logic [BUS_WIDTH-1:0] SYNC_BUS,
   output logic                 ENABLE_PULSE,
   output logic                 SYNC_VALID,
   input  logic                 SYNC_READY,
   output logic                 OVERRUN
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   logic [NUM_STAGES-1:0] sync_r;
   logic                  req_d_r;
   logic                  event_s;
   state_t                state_r;

   // Request synchronizer chain; only the last stage feeds the control logic.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[NUM_STAGES-2:0], BUS_REQ};
      end
   end

   // Delayed copy of the last sync stage, used for edge detection.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         req_d_r <= 1'b0;
      end else begin
         req_d_r <= sync_r[NUM_STAGES-1];
      end
   end

   // Any transition of the synchronized request is one new-word event.
   assign event_s = sync_r[NUM_STAGES-1] ^ req_d_r;

   // Capture/hold FSM with registered data, strobe, valid and acknowledge.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r      <= IDLE;
         SYNC_BUS     <= '0;
         ENABLE_PULSE <= 1'b0;
         SYNC_VALID   <= 1'b0;
         ACK_TGL      <= 1'b0;
      end else begin
         ENABLE_PULSE <= 1'b0;
         case (state_r)
            IDLE: begin
               if (event_s) begin
                  SYNC_BUS     <= UNSYNC_BUS;
                  ENABLE_PULSE <= 1'b1;
                  SYNC_VALID   <= 1'b1;
                  state_r      <= HOLD;
               end else begin
                  state_r      <= IDLE;
               end
            end
            HOLD: begin
               // Events arriving here are dropped; the held word is kept.
               if (SYNC_VALID && SYNC_READY) begin
                  SYNC_VALID <= 1'b0;
                  ACK_TGL    <= ~ACK_TGL;
                  state_r    <= IDLE;
               end else begin
                  state_r    <= HOLD;
               end
            end
            default: begin
               SYNC_VALID <= 1'b0;
               state_r    <= IDLE;
            end
         endcase
      end
   end

`ifdef DATA_SYNC_OVERRUN_EN
   // Sticky flag for a request that arrives while a word is still held.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         OVERRUN <= 1'b0;
      end else if ((state_r == HOLD) && event_s) begin
         OVERRUN <= 1'b1;
      end else begin
         OVERRUN <= OVERRUN;
      end
   end
`else
   assign OVERRUN = 1'b0;
`endif

endmodule

// File: tb/tb_data_sync.sv
// tb_data_sync: directed plus randomized check of data_sync (NUM_STAGES=3).
// Expected values come from the handshake rules: fixed request-to-pulse
// latency, in-order words from a queue, one ACK transition per accepted word.
module tb_data_sync;

   localparam int NS = 3;
   localparam int BW = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic [BW-1:0] UNSYNC_BUS;
   logic          BUS_REQ;
   logic          ACK_TGL;
   logic [BW-1:0] SYNC_BUS;
   logic          ENABLE_PULSE;
   logic          SYNC_VALID;
   logic          SYNC_READY;
   logic          OVERRUN;

   int            n_total = 0;
   int            n_pass  = 0;
   logic          exp_ack;
   logic          exp_ov;
   logic [BW-1:0] sent_q[$];
   logic [BW-1:0] held;

   data_sync #(.NUM_STAGES(NS), .BUS_WIDTH(BW)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .UNSYNC_BUS   (UNSYNC_BUS),
      .BUS_REQ      (BUS_REQ),
      .ACK_TGL      (ACK_TGL),
      .SYNC_BUS     (SYNC_BUS),
      .ENABLE_PULSE (ENABLE_PULSE),
      .SYNC_VALID   (SYNC_VALID),
      .SYNC_READY   (SYNC_READY),
      .OVERRUN      (OVERRUN)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Source side: present a word and announce it with a request transition.
   task automatic send(input logic [BW-1:0] d, input logic rdy);
      UNSYNC_BUS = d;
      BUS_REQ    = ~BUS_REQ;
      SYNC_READY = rdy;
      sent_q.push_back(d);
   endtask

   // Strobe must appear exactly NS+1 edges after the request transition.
   task automatic capture(output logic [BW-1:0] word);
      logic [BW-1:0] exp_d;
      exp_d = sent_q.pop_front();
      for (int n = 1; n <= NS; n++) begin
         tick();
         chk("pulse_early", ENABLE_PULSE, 1'b0);
      end
      tick();
      chk("pulse", ENABLE_PULSE, 1'b1);
      chk("valid_set", SYNC_VALID, 1'b1);
      chk("data", SYNC_BUS, exp_d);
      chk("ack_at_capture", ACK_TGL, exp_ack);
      word = exp_d;
   endtask

   // Hold the word for 'hold' cycles with READY low, then accept it.
   task automatic hold_accept(input logic [BW-1:0] d, input int hold);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_pulse", ENABLE_PULSE, 1'b0);
         chk("hold_valid", SYNC_VALID, 1'b1);
         chk("hold_data", SYNC_BUS, d);
         chk("hold_ack", ACK_TGL, exp_ack);
      end
      SYNC_READY = 1'b1;
      tick();
      exp_ack = ~exp_ack;
      chk("accept_valid", SYNC_VALID, 1'b0);
      chk("accept_ack", ACK_TGL, exp_ack);
      chk("accept_pulse", ENABLE_PULSE, 1'b0);
      chk("overrun", OVERRUN, exp_ov);
      SYNC_READY = 1'b0;
   endtask

   task automatic xfer(input logic [BW-1:0] d, input int hold);
      logic [BW-1:0] w;
      send(d, (hold == 0));
      capture(w);
      hold_accept(w, hold);
   endtask

   initial begin
      RST        = 1'b0;
      BUS_REQ    = 1'b0;
      UNSYNC_BUS = '0;
      SYNC_READY = 1'b0;
      exp_ack    = 1'b0;
      exp_ov     = 1'b0;
      #1;
      chk("rst_bus", SYNC_BUS, 8'h00);
      chk("rst_valid", SYNC_VALID, 1'b0);
      chk("rst_pulse", ENABLE_PULSE, 1'b0);
      chk("rst_ack", ACK_TGL, 1'b0);
      chk("rst_ovr", OVERRUN, 1'b0);
      tick();
      tick();
      RST = 1'b1;
      // Release with BUS_REQ low: no event.
      for (int i = 0; i < NS + 3; i++) begin
         tick();
         chk("rel_no_pulse", ENABLE_PULSE, 1'b0);
      end

      xfer(8'hA5, 0);
      xfer(8'h3C, 5);
      for (int i = 1; i <= 4; i++) xfer(8'(i), 0);
      for (int i = 0; i < 8; i++) xfer(8'($urandom), int'($urandom_range(0, 4)));

      // READY while nothing is held has no effect.
      SYNC_READY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("idle_ready_valid", SYNC_VALID, 1'b0);
         chk("idle_ready_ack", ACK_TGL, exp_ack);
      end
      SYNC_READY = 1'b0;

      // Protocol violation: two extra requests while a word is held.
      send(8'h5A, 1'b0);
      capture(held);
      for (int t = 0; t < 2; t++) begin
         UNSYNC_BUS = 8'hC3;
         BUS_REQ    = ~BUS_REQ;
         for (int i = 0; i < NS + 2; i++) begin
            tick();
            chk("ovr_no_pulse", ENABLE_PULSE, 1'b0);
            chk("ovr_data", SYNC_BUS, 8'h5A);
            chk("ovr_valid", SYNC_VALID, 1'b1);
            chk("ovr_ack", ACK_TGL, exp_ack);
         end
`ifdef DATA_SYNC_OVERRUN_EN
         exp_ov = 1'b1;
`endif
         chk("ovr_flag", OVERRUN, exp_ov);
      end
      hold_accept(held, 0);
      xfer(8'h11, 2);
      chk("ovr_sticky", OVERRUN, exp_ov);

      // Reset while a word is held.
      send(8'hFF, 1'b0);
      capture(held);
      RST = 1'b0;
      #1;
      chk("mid_rst_valid", SYNC_VALID, 1'b0);
      chk("mid_rst_bus", SYNC_BUS, 8'h00);
      chk("mid_rst_ack", ACK_TGL, 1'b0);
      chk("mid_rst_ovr", OVERRUN, 1'b0);
      exp_ack = 1'b0;
      exp_ov  = 1'b0;
      BUS_REQ = 1'b0;
      sent_q.delete();
      tick();
      tick();
      RST = 1'b1;
      for (int i = 0; i < NS + 3; i++) begin
         tick();
         chk("post_rst_no_pulse", ENABLE_PULSE, 1'b0);
         chk("post_rst_valid", SYNC_VALID, 1'b0);
      end
      xfer(8'h77, 1);

      // Request stuck high across reset release counts as one word.
      RST = 1'b0;
      BUS_REQ = 1'b1;
      UNSYNC_BUS = 8'h99;
      exp_ack = 1'b0;
      sent_q.delete();
      tick();
      RST = 1'b1;
      sent_q.push_back(8'h99);
      capture(held);
      hold_accept(held, 0);
      for (int i = 0; i < NS + 3; i++) begin
         tick();
         chk("stuck_single_pulse", ENABLE_PULSE, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/data_sync.md
DATA_SYNC -- requirements
Module: data_sync

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 2, number of synchronizer flops on the request path; legal range 2..8.
REQ-002 SHALL have parameter BUS_WIDTH, default 8, width of the transferred data word; legal range 1..32.
REQ-003 SHALL have port CLK  input  1  destination-domain clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port UNSYNC_BUS  input  BUS_WIDTH  data word from the source domain; held stable by the source while a request is outstanding.
REQ-006 SHALL have port BUS_REQ  input  1  toggle request from the source domain; each transition announces one new word.
REQ-007 SHALL have port ACK_TGL  output  1  toggle acknowledge returned to the source; each transition releases one word.
REQ-008 SHALL have port SYNC_BUS  output  BUS_WIDTH  captured word in the CLK domain.
REQ-009 SHALL have port ENABLE_PULSE  output  1  single-cycle strobe marking the cycle SYNC_BUS is updated.
REQ-010 SHALL have port SYNC_VALID  output  1  word held on SYNC_BUS awaiting the consumer.
REQ-011 SHALL have port SYNC_READY  input  1  consumer accepts the word.
REQ-012 SHALL have port OVERRUN  output  1  sticky protocol-violation flag.

Function
REQ-013 SHALL pass BUS_REQ through a NUM_STAGES flop chain; only the last stage is used by the control logic; UNSYNC_BUS is never sampled except at capture.
REQ-014 SHALL register the last sync stage once more; event = last stage XOR registered copy, a combinational signal.
REQ-015 SHALL implement FSM states IDLE and HOLD; reset state IDLE.
REQ-016 IDLE + event: SHALL capture UNSYNC_BUS into SYNC_BUS, assert ENABLE_PULSE for exactly one cycle, set SYNC_VALID, and go to HOLD, all on the same edge.
REQ-017 Latency: a BUS_REQ toggle first sampled at edge k SHALL produce ENABLE_PULSE and SYNC_VALID high after edge k+NUM_STAGES.
REQ-018 HOLD: SYNC_VALID and SYNC_BUS SHALL hold; on a cycle with SYNC_VALID=1 and SYNC_READY=1, the next edge SHALL clear SYNC_VALID, toggle ACK_TGL and return to IDLE.
REQ-019 SYNC_READY may be high before SYNC_VALID; earliest acceptance SHALL be the first cycle SYNC_VALID is high, giving a one-cycle HOLD.
REQ-020 ACK_TGL SHALL toggle exactly once per accepted word and never in IDLE.
REQ-021 An event while in HOLD, including the handshake-completion cycle, SHALL be a protocol violation: word not captured, no ENABLE_PULSE, no ACK_TGL change, OVERRUN handling per REQ-026/027.
REQ-022 SYNC_READY while SYNC_VALID=0 SHALL have no effect.

Reset
REQ-023 RST low SHALL asynchronously clear all sync flops, the registered copy, SYNC_BUS, ENABLE_PULSE, SYNC_VALID, ACK_TGL and OVERRUN to 0 and force IDLE.
REQ-024 Reset mid-transfer SHALL discard the held word without toggling ACK_TGL; the source domain is reset by the same RST and restarts with BUS_REQ=0.
REQ-025 After RST release, BUS_REQ=0 SHALL produce no event; a stuck BUS_REQ=1 at release SHALL be treated as one valid request.

Configuration
REQ-026 With macro DATA_SYNC_OVERRUN_EN defined, a REQ-021 violation SHALL set OVERRUN on the next edge, where it stays until RST.
REQ-027 Without DATA_SYNC_OVERRUN_EN, OVERRUN SHALL be constant 0, the port SHALL still exist, and violations SHALL be ignored as in REQ-021.

Verification
REQ-028 NUM_STAGES=2, RST released, UNSYNC_BUS=8'hA5, BUS_REQ 0->1, SYNC_READY=1 -> ENABLE_PULSE one cycle 2 edges after first sample, SYNC_BUS=A5, SYNC_VALID one cycle, ACK_TGL 0->1.
REQ-029 SYNC_READY=0 for 5 cycles after capture of 8'h3C -> SYNC_VALID and SYNC_BUS=3C held 5 cycles, ACK_TGL unchanged; SYNC_READY=1 -> ACK_TGL toggles next edge.
REQ-030 Four back-to-back words 01,02,03,04, source waiting for ACK each time, NUM_STAGES=3 -> four pulses, data in order, ACK_TGL toggles 4 times, OVERRUN=0.
REQ-031 With DATA_SYNC_OVERRUN_EN, toggle BUS_REQ twice while in HOLD -> OVERRUN=1 sticky, SYNC_BUS unchanged, single ENABLE_PULSE; without the macro, OVERRUN stays 0.
REQ-032 RST low while SYNC_VALID=1 with word 8'hFF -> SYNC_VALID, SYNC_BUS, ACK_TGL and OVERRUN = 0 immediately; after release, no pulse until next BUS_REQ toggle.
